// File: rtl/tlb_pkg.sv
// Shared constants, encodings and field helpers for the TLB maintenance sequencer.
package tlb_pkg;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned DATA_W  = 63;
  localparam int unsigned VPN_W   = 19;

  // Entry field layout
  localparam int unsigned VPN2_HI = 62;
  localparam int unsigned VPN2_LO = 44;
  localparam int unsigned PFN1_HI = 43;
  localparam int unsigned PFN1_LO = 24;
  localparam int unsigned D1      = 23;
  localparam int unsigned V1      = 22;
  localparam int unsigned PFN0_HI = 21;
  localparam int unsigned PFN0_LO = 2;
  localparam int unsigned D0      = 1;
  localparam int unsigned V0      = 0;

  typedef enum logic [1:0] {
    TLB_OP_WI = 2'b00,
    TLB_OP_WR = 2'b01,
    TLB_OP_P  = 2'b10,
    TLB_OP_R  = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_PROBE = 3'd3,
    ST_DONE  = 3'd4
  } tlb_state_e;

  // Extract the VPN2 tag used as the probe key
  function automatic logic [VPN_W-1:0] entry_vpn2(input logic [DATA_W-1:0] entry);
    return entry[VPN2_HI:VPN2_LO];
  endfunction

endpackage

// File: rtl/tlb_random_counter.sv
// CP0 Random register: free-running decrement that wraps at Wired and reloads on Wired writes.
module tlb_random_counter
  import tlb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] TOP = IDX_W'(ENTRIES - 1);

  // Reload has priority; reaching Wired wraps back to the top (also holds when Wired is the top)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      random <= TOP;
    end else if (wired_we || (random == wired)) begin
      random <= TOP;
    end else begin
      random <= random - IDX_W'(1);
    end
  end

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: TLBWI/TLBWR writes, TLBR read and a one-entry-per-cycle TLBP probe.
module tlb_maint_ctrl
  import tlb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  output logic              cmd_ready,
  input  logic [IDX_W-1:0]  cp0_index,
  input  logic [DATA_W-1:0] cp0_entry,
  input  logic [IDX_W-1:0]  cp0_wired,
  input  logic              cp0_wired_we,
  output logic              tlb_we,
  output logic [IDX_W-1:0]  tlb_index,
  output logic [DATA_W-1:0] tlb_data,
  output logic [IDX_W-1:0]  tlb_rindex,
  input  logic [DATA_W-1:0] tlb_rdata,
  output logic              done,
  output logic              probe_hit,
  output logic [IDX_W-1:0]  probe_index,
  output logic [DATA_W-1:0] read_data,
  output logic [IDX_W-1:0]  random,
  output logic              stall_req
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  tlb_state_e        state_q, state_d;
  logic              we_d, done_d, ready_d, hit_d;
  logic [IDX_W-1:0]  index_d, rindex_d, pidx_d;
  logic [DATA_W-1:0] data_d, rdata_d;
  logic              accept;
  logic              key_match;

  tlb_random_counter u_random (
    .clk      (clk),
    .rst      (rst),
    .wired    (cp0_wired),
    .wired_we (cp0_wired_we),
    .random   (random)
  );

  assign accept    = cmd_valid & cmd_ready;
  assign key_match = (entry_vpn2(tlb_rdata) == entry_vpn2(tlb_data));
  assign stall_req = ~cmd_ready | accept;

  // Next state and next values of every registered output; tlb_index/tlb_data double as the command latch
  always_comb begin
    state_d  = state_q;
    index_d  = tlb_index;
    data_d   = tlb_data;
    rindex_d = tlb_rindex;
    hit_d    = probe_hit;
    pidx_d   = probe_index;
    rdata_d  = read_data;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d = cp0_entry;
          case (tlb_op_e'(cmd_op))
            TLB_OP_WI: begin
              index_d = cp0_index;
              state_d = ST_WRITE;
            end
            TLB_OP_WR: begin
              index_d = random;
              state_d = ST_WRITE;
            end
            TLB_OP_R: begin
              index_d  = cp0_index;
              rindex_d = cp0_index;
              state_d  = ST_READ;
            end
            default: begin
              rindex_d = '0;
              state_d  = ST_PROBE;
            end
          endcase
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ: begin
        rdata_d = tlb_rdata;
        state_d = ST_DONE;
      end
      ST_PROBE: begin
        if (key_match) begin
          hit_d   = 1'b1;
          pidx_d  = tlb_rindex;
          state_d = ST_DONE;
        end else if (tlb_rindex == LAST_IDX) begin
          hit_d   = 1'b0;
          pidx_d  = '0;
          state_d = ST_DONE;
        end else begin
          rindex_d = tlb_rindex + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    we_d    = (state_d == ST_WRITE);
    done_d  = (state_d == ST_WRITE) || (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset aborts any operation without a write or done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_ready   <= 1'b1;
      tlb_we      <= 1'b0;
      tlb_index   <= '0;
      tlb_data    <= '0;
      tlb_rindex  <= '0;
      done        <= 1'b0;
      probe_hit   <= 1'b0;
      probe_index <= '0;
      read_data   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready   <= ready_d;
      tlb_we      <= we_d;
      tlb_index   <= index_d;
      tlb_data    <= data_d;
      tlb_rindex  <= rindex_d;
      done        <= done_d;
      probe_hit   <= hit_d;
      probe_index <= pidx_d;
      read_data   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl with a behavioural 16-entry TLB array.
module tb_tlb_maint_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic [3:0]  cp0_index;
  logic [62:0] cp0_entry;
  logic [3:0]  cp0_wired;
  logic        cp0_wired_we;
  logic        tlb_we;
  logic [3:0]  tlb_index;
  logic [62:0] tlb_data;
  logic [3:0]  tlb_rindex;
  logic [62:0] tlb_rdata;
  logic        done;
  logic        probe_hit;
  logic [3:0]  probe_index;
  logic [62:0] read_data;
  logic [3:0]  random;
  logic        stall_req;

  logic [62:0] mem [16];
  logic        pl_we;
  logic [3:0]  pl_idx;
  logic [62:0] pl_data;

  int checks   = 0;
  int failures = 0;
  int lat;
  logic we_seen;

  localparam logic [62:0] KEY_HIT  = {19'h1234A, 44'h0};
  localparam logic [62:0] KEY_MISS = {19'h7FFFF, 44'h0};
  localparam logic [62:0] E_WR     = {19'h00ABC, 44'h0000_0000_9A5};
  localparam logic [62:0] E_WI     = {19'h00010, 44'h0000_0000_123};
  localparam logic [62:0] E_R12    = 63'h5A5A5A5A5A5A5A5A;
  localparam logic [62:0] E_WI2    = {19'h00222, 44'h0000_0ABC_DEF};

  tlb_maint_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_ready    (cmd_ready),
    .cp0_index    (cp0_index),
    .cp0_entry    (cp0_entry),
    .cp0_wired    (cp0_wired),
    .cp0_wired_we (cp0_wired_we),
    .tlb_we       (tlb_we),
    .tlb_index    (tlb_index),
    .tlb_data     (tlb_data),
    .tlb_rindex   (tlb_rindex),
    .tlb_rdata    (tlb_rdata),
    .done         (done),
    .probe_hit    (probe_hit),
    .probe_index  (probe_index),
    .read_data    (read_data),
    .random       (random),
    .stall_req    (stall_req)
  );

  always #5 clk = ~clk;

  // TLB array model: bench preload port or DUT write port
  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    else if (tlb_we) mem[tlb_index] <= tlb_data;
  end

  assign tlb_rdata = mem[tlb_rindex];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge
  task automatic preload(input logic [3:0] idx, input logic [62:0] data);
    pl_we = 1'b1;
    pl_idx = idx;
    pl_data = data;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of T+1 with inputs scrambled
  task automatic issue(input logic [1:0] op, input logic [3:0] idx, input logic [62:0] ent);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cp0_index = idx;
    cp0_entry = ent;
    @(negedge clk);
    cmd_valid = 1'b0;
    cp0_index = 4'hF;
    cp0_entry = '1;
  endtask

  // Cycles from accept (T) to done, bounded; lat=0 if done never seen
  task automatic wait_done(output int l, output logic ws);
    l  = 0;
    ws = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      ws = ws | tlb_we;
      if (done) begin
        l = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cp0_index = '0;
    cp0_entry = '0;
    cp0_wired = 4'd2;
    cp0_wired_we = 1'b0;
    pl_we = 1'b0;
    pl_idx = '0;
    pl_data = '0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) preload(4'(i), {19'(32'h100 + i), 44'(i)});
    preload(4'd3, {19'h1234A, 44'h3});
    preload(4'd7, {19'h1234A, 44'h7});
    preload(4'd12, E_R12);

    // Reset values
    check("rst_random", 64'(random), 64'd15);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_we", 64'(tlb_we), 64'd0);
    check("rst_read_data", 64'(read_data), 64'd0);

    // Random sequence with Wired=2
    rst = 1'b1;
    #1 check("rand_0", 64'(random), 64'd15);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check("rand_seq", 64'(random), (k <= 13) ? 64'(15 - k) : 64'd15);
    end
    repeat (3) @(negedge clk);
    check("rand_pre_we", 64'(random), 64'd12);
    cp0_wired_we = 1'b1;
    @(negedge clk);
    cp0_wired_we = 1'b0;
    check("rand_reload", 64'(random), 64'd15);
    repeat (6) @(negedge clk);
    check("rand_at_wr", 64'(random), 64'd9);

    // TLBWR takes current Random
    issue(2'b01, 4'd0, E_WR);
    check("wr_we", 64'(tlb_we), 64'd1);
    check("wr_index", 64'(tlb_index), 64'd9);
    check("wr_done", 64'(done), 64'd1);
    @(negedge clk);
    check("wr_we_off", 64'(tlb_we), 64'd0);
    check("wr_mem", 64'(mem[9]), 64'(E_WR));

    // TLBWI index 5
    issue(2'b00, 4'd5, E_WI);
    check("wi_we", 64'(tlb_we), 64'd1);
    check("wi_index", 64'(tlb_index), 64'd5);
    check("wi_data", 64'(tlb_data), 64'(E_WI));
    check("wi_done", 64'(done), 64'd1);
    check("wi_ready", 64'(cmd_ready), 64'd0);
    check("wi_stall", 64'(stall_req), 64'd1);
    @(negedge clk);
    check("wi_we_off", 64'(tlb_we), 64'd0);
    check("wi_done_off", 64'(done), 64'd0);
    check("wi_ready_back", 64'(cmd_ready), 64'd1);
    check("wi_mem", 64'(mem[5]), 64'(E_WI));

    // TLBP: entries 3 and 7 match, lowest wins
    issue(2'b10, 4'd0, KEY_HIT);
    wait_done(lat, we_seen);
    check("ph_latency", 64'(lat), 64'd5);
    check("ph_hit", 64'(probe_hit), 64'd1);
    check("ph_index", 64'(probe_index), 64'd3);
    check("ph_no_we", 64'(we_seen), 64'd0);
    @(negedge clk);
    check("ph_done_pulse", 64'(done), 64'd0);
    check("ph_hold", 64'(probe_hit), 64'd1);

    // TLBP miss scans all 16 entries
    issue(2'b10, 4'd0, KEY_MISS);
    wait_done(lat, we_seen);
    check("pm_latency", 64'(lat), 64'd17);
    check("pm_hit", 64'(probe_hit), 64'd0);
    check("pm_index", 64'(probe_index), 64'd0);
    check("pm_no_we", 64'(we_seen), 64'd0);
    @(negedge clk);

    // TLBR index 12 with a second command held valid while busy
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    cp0_index = 4'd12;
    cp0_entry = '0;
    @(negedge clk);
    cmd_op = 2'b00;
    cp0_index = 4'd2;
    cp0_entry = E_WI2;
    check("rd_t1_ready", 64'(cmd_ready), 64'd0);
    check("rd_t1_stall", 64'(stall_req), 64'd1);
    check("rd_t1_we", 64'(tlb_we), 64'd0);
    @(negedge clk);
    check("rd_t2_done", 64'(done), 64'd1);
    check("rd_t2_data", 64'(read_data), 64'(E_R12));
    check("rd_t2_ready", 64'(cmd_ready), 64'd0);
    check("rd_t2_we", 64'(tlb_we), 64'd0);
    @(negedge clk);
    check("rd_t3_ready", 64'(cmd_ready), 64'd1);
    check("rd_t3_stall", 64'(stall_req), 64'd1);
    check("rd_t3_we", 64'(tlb_we), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held_we", 64'(tlb_we), 64'd1);
    check("held_index", 64'(tlb_index), 64'd2);
    check("held_data", 64'(tlb_data), 64'(E_WI2));
    check("rd_hold", 64'(read_data), 64'(E_R12));
    @(negedge clk);

    // Reset during probe at counter 6
    issue(2'b10, 4'd0, KEY_MISS);
    repeat (6) @(negedge clk);
    check("ab_rindex", 64'(tlb_rindex), 64'd6);
    rst = 1'b0;
    #1;
    check("ab_done", 64'(done), 64'd0);
    check("ab_rindex0", 64'(tlb_rindex), 64'd0);
    check("ab_ready", 64'(cmd_ready), 64'd1);
    check("ab_read_data", 64'(read_data), 64'd0);
    check("ab_index", 64'(tlb_index), 64'd0);
    check("ab_random", 64'(random), 64'd15);
    repeat (2) @(negedge clk);
    check("ab_done_held", 64'(done), 64'd0);
    check("ab_we_held", 64'(tlb_we), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    issue(2'b10, 4'd0, KEY_HIT);
    wait_done(lat, we_seen);
    check("pr_latency", 64'(lat), 64'd5);
    check("pr_hit", 64'(probe_hit), 64'd1);
    check("pr_index", 64'(probe_index), 64'd3);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlb_maint_ctrl.md
Name: tlb_maint_ctrl

Overview:
Sequencer for TLB maintenance instructions (TLBWI, TLBWR, TLBP, TLBR) issued from the MEM/CP0 stage. It owns the TLB write port (we/index/data) and a combinational read port on the 16-entry TLB array. It runs the multi-cycle associative probe one entry per cycle, maintains the CP0 Random register, and stalls the pipeline while busy.

Parameters:
ENTRIES, 16, number of TLB entries
IDX_W, 4, index width (log2 ENTRIES)
DATA_W, 63, entry width: [62:44] VPN2, [43:24] PFN1, [23] D1, [22] V1, [21:2] PFN0, [1] D0, [0] V0
VPN_W, 19, VPN2 width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
cmd_valid  in  1  maintenance command request
cmd_op  in  2  00 TLBWI, 01 TLBWR, 10 TLBP, 11 TLBR
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid&cmd_ready
cp0_index  in  IDX_W  CP0 Index for TLBWI/TLBR
cp0_entry  in  DATA_W  assembled EntryHi/EntryLo0/EntryLo1 for writes; [62:44] is the probe key
cp0_wired  in  IDX_W  CP0 Wired
cp0_wired_we  in  1  pulse when Wired is written
tlb_we  out  1  TLB write strobe
tlb_index  out  IDX_W  TLB write index
tlb_data  out  DATA_W  TLB write data
tlb_rindex  out  IDX_W  TLB read index
tlb_rdata  in  DATA_W  combinational TLB read data for tlb_rindex
done  out  1  one-cycle completion pulse
probe_hit  out  1  TLBP result valid-hit (Index.P = ~probe_hit)
probe_index  out  IDX_W  TLBP matching index
read_data  out  DATA_W  TLBR result
random  out  IDX_W  CP0 Random value
stall_req  out  1  pipeline stall, = ~cmd_ready | (cmd_valid & cmd_ready)

Behaviour:
- Reset (rst=0, async): state=IDLE; tlb_we=0; tlb_index=0; tlb_data=0; tlb_rindex=0; done=0; probe_hit=0; probe_index=0; read_data=0; random=ENTRIES-1.
- Random: decrements by 1 every cycle. When random==cp0_wired, it wraps to ENTRIES-1 next cycle. If cp0_wired==ENTRIES-1, it holds at ENTRIES-1. On cp0_wired_we, it loads ENTRIES-1; this has priority over decrement.
- FSM states: IDLE, WRITE, READ, PROBE, DONE.
- IDLE: on accept, latch op, cp0_entry, and the target index. The index is cp0_index for TLBWI/TLBR and the current random for TLBWR. Probe counter is cleared to 0.
  - TLBWI/TLBWR go to WRITE.
  - TLBR goes to READ.
  - TLBP goes to PROBE.
- WRITE (1 cycle): tlb_we=1, tlb_index=latched index, tlb_data=latched entry, done=1. Then IDLE. Total latency from accept cycle T: write lands at edge ending T+1.
- READ: tlb_rindex=latched index; read_data<=tlb_rdata at end of cycle; go to DONE. done is seen in T+2, with read_data valid in that same cycle.
- PROBE: tlb_rindex=counter. Compare tlb_rdata[62:44] with latched key.
  - Match: probe_hit<=1, probe_index<=counter, go to DONE.
  - No match and counter==ENTRIES-1: probe_hit<=0, probe_index<=0, go to DONE.
  - Otherwise counter+1.
  - Result is the lowest matching index. Latency is T+2 (hit at entry 0) to T+17 (miss).
- DONE: done=1 for one cycle, then IDLE. probe_hit, probe_index and read_data hold until overwritten by the next TLBP or TLBR.
- tlb_we is 0 in every state except WRITE; tlb_we never asserts during PROBE or READ.
- A cmd_valid while busy is ignored; the requester holds cmd_valid and stall_req keeps the pipe frozen.
- Changes to cp0_index or cp0_entry after accept have no effect.
- Reset asserted mid-operation aborts to IDLE immediately. No write is issued and done is not pulsed.
- An unknown state recovers to IDLE.

Decomposition:
- Shared package tlb_pkg:
  - op encodings TLB_OP_WI/WR/P/R
  - FSM state encoding
  - ENTRIES/IDX_W/DATA_W constants
  - field ranges VPN2_HI/LO, PFN1, D1, V1, PFN0, D0, V0
- Sub-module tlb_random_counter: Random register with wired wrap and reload.

Test Plan:
- TLBWI with cp0_index=5 and entry VPN2=0x00010 -> tlb_we=1 for exactly one cycle at T+1 with tlb_index=5; done in the same cycle.
- Reset release with wired=2 -> random counts 15,14,…,2,15. Pulse cp0_wired_we mid-count -> random=15 next cycle. TLBWR accepted when random=9 -> tlb_index=9.
- Entries 3 and 7 both hold VPN2=0x1234A, then TLBP with key 0x1234A -> probe_hit=1, probe_index=3, done at T+5.
- TLBP with key absent from all entries -> done at T+17, probe_hit=0, probe_index=0, and tlb_we never asserts.
- TLBR on index 12 holding 0x5A5A5A5A5A5A5A5A (masked to 63 bits) -> read_data equals it with done at T+2. cmd_valid held during busy -> second command accepted only after IDLE.
- rst low during PROBE at counter=6 -> all outputs reset immediately, no done pulse, and the next TLBP after release behaves normally.
